clock_reset_ctrl: RTL and testbench



---
 rtl/clock_reset_ctrl.sv | 128 ++++++++++++
 tb/tb_clock_reset_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_reset_ctrl.sv
// DCM reset sequencer: pulses DCM reset, qualifies lock, releases system reset.
// Optional status counters enabled by CLOCK_RESET_CTRL_STATUS_EN.
module clock_reset_ctrl #(
  parameter int unsigned DCM_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 20000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       DCM_LOCKED,
  output logic       DCM_RESET,
  output logic       SYS_RESET_N,
`ifdef CLOCK_RESET_CTRL_STATUS_EN
  output logic [7:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
`endif
  output logic       READY
);

  localparam logic [1:0] ST_RST_DCM   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lock_s;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dcm_rst_q;
  logic             sys_rst_n_q;
  logic             ready_q;

  assign lock_s = sync2_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= DCM_LOCKED;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      ST_RST_DCM: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                 state_d = ST_STABLE;
        else if (cnt_q == TMO_LAST) state_d = ST_RST_DCM;
      end
      ST_STABLE: begin
        if (!lock_s)                state_d = ST_RST_DCM;
        else if (cnt_q == STB_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = ST_RST_DCM;
      end
      default: state_d = ST_RST_DCM;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode state_d so they switch on the same edge as the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_RST_DCM;
      cnt_q       <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcm_rst_q   <= (state_d == ST_RST_DCM);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign DCM_RESET   = dcm_rst_q;
  assign SYS_RESET_N = sys_rst_n_q;
  assign READY       = ready_q;

`ifdef CLOCK_RESET_CTRL_STATUS_EN
  logic       tmo_ev;
  logic       loss_ev;
  logic [7:0] retry_q;
  logic [7:0] loss_q;

  assign tmo_ev  = (state_q == ST_WAIT_LOCK) && !lock_s &&
                   (cnt_q == TMO_LAST);
  assign loss_ev = ((state_q == ST_STABLE) ||
                    (state_q == ST_RUN)) && !lock_s;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (tmo_ev && retry_q != 8'hFF)
        retry_q <= retry_q + 8'd1;
      if (loss_ev && loss_q != 8'hFF)
        loss_q <= loss_q + 8'd1;
    end
  end

  assign RETRY_CNT = retry_q;
  assign LOSS_CNT  = loss_q;
`endif

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Bench for clock_reset_ctrl: directed timing checks plus random lock
// patterns against a phase/elapsed-time reference model.
module tb_clock_reset_ctrl;

  localparam int DRC = 4;
  localparam int LTO = 50;
  localparam int STC = 8;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       DCM_LOCKED;
  logic       DCM_RESET;
  logic       SYS_RESET_N;
  logic       READY;
`ifdef CLOCK_RESET_CTRL_STATUS_EN
  logic [7:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;
`endif

  clock_reset_ctrl #(
    .DCM_RST_CYCLES(DRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .CNT_W         (16)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .DCM_LOCKED (DCM_LOCKED),
    .DCM_RESET  (DCM_RESET),
    .SYS_RESET_N(SYS_RESET_N),
`ifdef CLOCK_RESET_CTRL_STATUS_EN
    .RETRY_CNT  (RETRY_CNT),
    .LOSS_CNT   (LOSS_CNT),
`endif
    .READY      (READY)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: which phase we are in and how long we have been in it.
  typedef enum {M_PULSE, M_WAIT, M_QUAL, M_RUN} mph_e;
  mph_e     m_ph;
  int       m_t;
  bit [1:0] m_hist;
  int       m_retry;
  int       m_loss;

  task automatic model_reset();
    m_ph    = M_PULSE;
    m_t     = 0;
    m_hist  = 2'b00;
    m_retry = 0;
    m_loss  = 0;
  endtask

  task automatic enter(input mph_e p);
    m_ph = p;
    m_t  = 0;
  endtask

  task automatic model_step(input logic lk);
    bit ls;
    ls     = m_hist[1];
    m_hist = {m_hist[0], lk};
    case (m_ph)
      M_PULSE:
        if (m_t + 1 >= DRC) enter(M_WAIT);
        else m_t++;
      M_WAIT:
        if (ls) enter(M_QUAL);
        else if (m_t + 1 >= LTO) begin
          m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          enter(M_PULSE);
        end else m_t++;
      M_QUAL:
        if (!ls) begin
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          enter(M_PULSE);
        end else if (m_t + 1 >= STC) enter(M_RUN);
        else m_t++;
      default:
        if (!ls) begin
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          enter(M_PULSE);
        end
    endcase
  endtask

  task automatic check_outs();
    chk("dcm_reset", 32'(DCM_RESET), 32'(m_ph == M_PULSE));
    chk("sys_reset_n", 32'(SYS_RESET_N), 32'(m_ph == M_RUN));
    chk("ready", 32'(READY), 32'(m_ph == M_RUN));
`ifdef CLOCK_RESET_CTRL_STATUS_EN
    chk("retry_cnt", 32'(RETRY_CNT), 32'(m_retry));
    chk("loss_cnt", 32'(LOSS_CNT), 32'(m_loss));
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(DCM_LOCKED);
    @(negedge CLK);
    check_outs();
  endtask

  task automatic async_reset_mid();
    @(posedge CLK);
    model_step(DCM_LOCKED);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_dcm", 32'(DCM_RESET), 32'd1);
    chk("async_sys", 32'(SYS_RESET_N), 32'd0);
    chk("async_ready", 32'(READY), 32'd0);
`ifdef CLOCK_RESET_CTRL_STATUS_EN
    chk("async_retry", 32'(RETRY_CNT), 32'd0);
    chk("async_loss", 32'(LOSS_CNT), 32'd0);
`endif
    model_reset();
    @(negedge CLK);
    check_outs();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    bit lvl;
    int left;
    RESET_N    = 1'b0;
    DCM_LOCKED = 1'b0;
    model_reset();
    repeat (5) @(negedge CLK);
    check_outs();
    RESET_N = 1'b1;

    // Power-up: lock from cycle 10, release on edge 10+2+STC.
    for (int c = 1; c <= 25; c++) begin
      DCM_LOCKED = (c >= 10);
      tick();
      chk("pu_dcm", 32'(DCM_RESET), 32'(c <= DRC - 1));
      chk("pu_sys", 32'(SYS_RESET_N), 32'(c >= 10 + 2 + STC));
    end

    // Random lock/unlock segments with occasional async resets.
    lvl  = 1'b1;
    left = $urandom_range(1, 40);
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl  = !lvl;
        left = lvl ? $urandom_range(1, 40)
                   : $urandom_range(1, 130);
      end
      DCM_LOCKED = lvl;
      left--;
      if ($urandom_range(0, 299) == 0) async_reset_mid();
      else tick();
    end

    // Lock qualifies exactly on the timeout cycle: lock wins.
    DCM_LOCKED = 1'b0;
    async_reset_mid();
    for (int c = 1; c <= 70; c++) begin
      DCM_LOCKED = (c >= 52);
      tick();
      if (c >= DRC)
        chk("simul_dcm", 32'(DCM_RESET), 32'd0);
      chk("simul_sys", 32'(SYS_RESET_N), 32'(c >= 52 + 2 + STC));
    end
`ifdef CLOCK_RESET_CTRL_STATUS_EN
    chk("simul_retry", 32'(RETRY_CNT), 32'd0);
`endif

    // Lock loss in RUN, then recovery.
    for (int c = 71; c <= 100; c++) begin
      DCM_LOCKED = (c >= 81);
      tick();
      if (c <= 80) begin
        chk("loss_sys", 32'(SYS_RESET_N), 32'(c < 73));
        chk("loss_dcm", 32'(DCM_RESET),
            32'(c >= 73 && c <= 72 + DRC));
      end else begin
        chk("recov_sys", 32'(SYS_RESET_N), 32'(c >= 81 + 2 + STC));
      end
    end
`ifdef CLOCK_RESET_CTRL_STATUS_EN
    chk("loss_cnt_one", 32'(LOSS_CNT), 32'd1);
`endif

    // Async reset while in RUN.
    async_reset_mid();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
